dp_onchip_ram_ctrl: RTL and testbench

Parametrised true-dual-port on-chip RAM with two Avalon-MM slave ports (s1, s2), the next generation of the team's fixed-geometry dual-port on-chip memory. Adds configurable width and depth, an optional output register, explicit `readdatavalid`/`waitrequest` handshakes, deterministic same-address collision rules, and a clear-on-reset sweep engine. Sits between the fabric interconnect and block RAM in memory-test and buffer subsystems.

---
 rtl/dp_onchip_ram_ctrl.sv | 121 ++++++++++++
 tb/tb_dp_onchip_ram_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_onchip_ram_ctrl.sv
// True-dual-port Avalon-MM on-chip RAM with per-byte writes, port-1-wins collisions,
// read-before-write across ports, optional output register and a clear-on-reset sweep.
module dp_onchip_ram_ctrl #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH = 64,
  parameter int OUTPUT_REG = 0,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  input  logic                    clken2,
  input  logic                    chipselect2,
  input  logic                    read2,
  input  logic                    write2,
  input  logic [ADDR_WIDTH-1:0]   address2,
  input  logic [DATA_WIDTH/8-1:0] byteenable2,
  input  logic [DATA_WIDTH-1:0]   writedata2,
  output logic [DATA_WIDTH-1:0]   readdata2,
  output logic                    readdatavalid2,
  output logic                    waitrequest2
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int STAGES = 1 + OUTPUT_REG;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;
  state_t                state;
  logic [ADDR_WIDTH:0]   sweep;

  logic [1:0]                       clken_v, cs_v, rd_v, wr_v, wait_v, acc_rd, acc_wr, in_rng, rvld;
  logic [1:0][ADDR_WIDTH-1:0]       addr_v;
  logic [1:0][BE_WIDTH-1:0]         be_v;
  logic [1:0][DATA_WIDTH-1:0]       wd_v, rdat;
  logic [DATA_WIDTH-1:0]            mem [DEPTH];

  assign clken_v = {clken2, clken};
  assign cs_v    = {chipselect2, chipselect};
  assign rd_v    = {read2, read};
  assign wr_v    = {write2, write};
  assign addr_v  = {address2, address};
  assign be_v    = {byteenable2, byteenable};
  assign wd_v    = {writedata2, writedata};

  // read+write on one port counts as a write only
  always_comb begin
    wait_v = '0;
    acc_rd = '0;
    acc_wr = '0;
    in_rng = '0;
    for (int p = 0; p < 2; p++) begin
      wait_v[p] = reset | (state == CLEAR) | ~clken_v[p];
      acc_wr[p] = cs_v[p] & wr_v[p] & ~wait_v[p];
      acc_rd[p] = cs_v[p] & rd_v[p] & ~wr_v[p] & ~wait_v[p];
      in_rng[p] = {1'b0, addr_v[p]} < DEPTH_W;
    end
  end

  assign waitrequest  = wait_v[0];
  assign waitrequest2 = wait_v[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      sweep <= '0;
    end else if (state == CLEAR) begin
      if (CLEAR_ON_RESET == 0 || sweep == LAST) state <= READY;
      else sweep <= sweep + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == CLEAR) begin
      if (CLEAR_ON_RESET != 0) mem[sweep[ADDR_WIDTH-1:0]] <= CLEAR_VALUE;
    end else begin
      // port 2 is applied first so port 1 overrides the bytes it enables
      for (int p = 1; p >= 0; p--)
        if (acc_wr[p] && in_rng[p])
          for (int b = 0; b < BE_WIDTH; b++)
            if (be_v[p][b]) mem[addr_v[p]][b*8 +: 8] <= wd_v[p][b*8 +: 8];
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [STAGES:0]                 vld_pipe;
    logic [STAGES:0][DATA_WIDTH-1:0] dat_pipe;

    // stage 0 samples the array before this edge's writes land: read-before-write
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_pipe <= '0;
        dat_pipe <= '0;
      end else begin
        vld_pipe <= {vld_pipe[STAGES-1:0], acc_rd[p]};
        if (acc_rd[p]) dat_pipe[0] <= in_rng[p] ? mem[addr_v[p]] : '0;
        for (int s = 1; s <= STAGES; s++)
          if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end

    assign rvld[p] = vld_pipe[STAGES];
    assign rdat[p] = dat_pipe[STAGES];
  end

  assign readdata       = rdat[0];
  assign readdata2      = rdat[1];
  assign readdatavalid  = rvld[0];
  assign readdatavalid2 = rvld[1];
endmodule

// File: tb/tb_dp_onchip_ram_ctrl.sv
// Bench for dp_onchip_ram_ctrl: two instances (OUTPUT_REG 0 and 1) share stimulus and are
// checked every cycle against a word-array model plus directed literal expectations.
module tb_dp_onchip_ram_ctrl;
  localparam int DW = 64, AW = 6, DEPTH = 48, BEW = DW / 8;
  localparam logic [DW-1:0] CV = '0;

  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] clken, cs, rd, wr;
  logic [1:0][AW-1:0] addr;
  logic [1:0][BEW-1:0] be;
  logic [1:0][DW-1:0] wd;
  logic [1:0][1:0][DW-1:0] rdata;   // [instance][port]
  logic [1:0][1:0] rvld, wreq;

  always #5 clk = ~clk;

  dp_onchip_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .OUTPUT_REG(0),
                       .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)) u_r0 (
    .clk(clk), .reset(reset),
    .clken(clken[0]), .chipselect(cs[0]), .read(rd[0]), .write(wr[0]), .address(addr[0]),
    .byteenable(be[0]), .writedata(wd[0]), .readdata(rdata[0][0]),
    .readdatavalid(rvld[0][0]), .waitrequest(wreq[0][0]),
    .clken2(clken[1]), .chipselect2(cs[1]), .read2(rd[1]), .write2(wr[1]), .address2(addr[1]),
    .byteenable2(be[1]), .writedata2(wd[1]), .readdata2(rdata[0][1]),
    .readdatavalid2(rvld[0][1]), .waitrequest2(wreq[0][1]));

  dp_onchip_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .OUTPUT_REG(1),
                       .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)) u_r1 (
    .clk(clk), .reset(reset),
    .clken(clken[0]), .chipselect(cs[0]), .read(rd[0]), .write(wr[0]), .address(addr[0]),
    .byteenable(be[0]), .writedata(wd[0]), .readdata(rdata[1][0]),
    .readdatavalid(rvld[1][0]), .waitrequest(wreq[1][0]),
    .clken2(clken[1]), .chipselect2(cs[1]), .read2(rd[1]), .write2(wr[1]), .address2(addr[1]),
    .byteenable2(be[1]), .writedata2(wd[1]), .readdata2(rdata[1][1]),
    .readdatavalid2(rvld[1][1]), .waitrequest2(wreq[1][1]));

  typedef struct { int due; logic [DW-1:0] d; } exp_t;
  exp_t q[4][$];                     // index = instance*2 + port
  logic [DW-1:0] mmem [DEPTH];
  logic [DW-1:0] last [4];
  int busy = 0, cyc = 0;
  bit armed = 1'b0;
  int n_cmp = 0, n_bad = 0;
  int vcnt [2][2] = '{'{0, 0}, '{0, 0}};

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: reset fills the array and blocks both ports for DEPTH cycles; afterwards each
  // accepted read returns the pre-edge word (0 out of range) 1+OUTPUT_REG edges later.
  always @(posedge clk) begin : model
    logic [DW-1:0] rv [2];
    bit racc [2];
    cyc++;
    if (reset) begin
      armed = 1'b1;
      busy = DEPTH;
      foreach (mmem[i]) mmem[i] = CV;
      for (int k = 0; k < 4; k++) begin
        q[k].delete();
        last[k] = '0;
      end
    end else if (busy > 0) begin
      busy--;
    end else begin
      for (int p = 0; p < 2; p++) begin
        racc[p] = cs[p] && rd[p] && !wr[p] && clken[p];
        rv[p] = (addr[p] < DEPTH) ? mmem[addr[p]] : '0;
      end
      for (int p = 1; p >= 0; p--)
        if (cs[p] && wr[p] && clken[p] && addr[p] < DEPTH)
          for (int b = 0; b < BEW; b++)
            if (be[p][b]) mmem[addr[p]][b*8 +: 8] = wd[p][b*8 +: 8];
      for (int p = 0; p < 2; p++)
        if (racc[p])
          for (int d = 0; d < 2; d++) q[d*2+p].push_back('{cyc + 1 + d, rv[p]});
    end
  end

  always @(negedge clk) begin : compare
    int k;
    logic ev;
    logic [DW-1:0] ed;
    if (armed) begin
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) begin
          k = d*2 + p;
          ev = 1'b0;
          ed = last[k];
          if (q[k].size() > 0 && q[k][0].due == cyc) begin
            ev = 1'b1;
            ed = q[k][0].d;
            last[k] = ed;
            void'(q[k].pop_front());
          end
          chk($sformatf("rvld_r%0d_p%0d", d, p+1), DW'(rvld[d][p]), DW'(ev));
          chk($sformatf("rdata_r%0d_p%0d", d, p+1), rdata[d][p], ed);
          chk($sformatf("wreq_r%0d_p%0d", d, p+1), DW'(wreq[d][p]),
              DW'(reset || busy > 0 || !clken[p]));
        end
    end
  end

  always @(negedge clk)
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++)
        if (rvld[d][p] === 1'b1) vcnt[d][p]++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cs = '0; rd = '0; wr = '0;
  endtask

  task automatic finish_reset(output int n);
    reset = 1'b0;
    #1;
    n = 0;
    while (wreq[0][0] && n < 200) begin
      n++;
      step();
    end
  endtask

  task automatic do_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [BEW-1:0] b);
    cs[p] = 1'b1; wr[p] = 1'b1; rd[p] = 1'b0; addr[p] = a; wd[p] = d; be[p] = b;
    step();
    cs[p] = 1'b0; wr[p] = 1'b0;
  endtask

  task automatic wait_rsp(input int p, output logic [DW-1:0] d0, output int l0, output int l1);
    l0 = -1; l1 = -1; d0 = '0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (l0 < 0 && rvld[0][p]) begin l0 = k; d0 = rdata[0][p]; end
      if (l1 < 0 && rvld[1][p]) l1 = k;
    end
  endtask

  task automatic do_rd(input int p, input logic [AW-1:0] a, output logic [DW-1:0] d0,
                       output int l0, output int l1);
    cs[p] = 1'b1; rd[p] = 1'b1; wr[p] = 1'b0; addr[p] = a;
    step();
    cs[p] = 1'b0; rd[p] = 1'b0;
    wait_rsp(p, d0, l0, l1);
  endtask

  initial begin
    logic [DW-1:0] d;
    int l0, l1, n, wcnt;
    int v0 [2][2];
    clken = '1; idle(); addr = '0; be = '0; wd = '0; reset = 1'b1;
    repeat (2) step();
    chk("rst_wreq", DW'(wreq[0][0]), DW'(1));
    chk("rst_rvld", DW'(rvld[1][1]), DW'(0));
    chk("rst_rdata", rdata[0][1], '0);
    finish_reset(n);
    chk("busy_initial", DW'(n), DW'(DEPTH));

    for (int a = 0; a < DEPTH; a++) do_wr(0, AW'(a), {8{8'hA5}}, '1);
    do_rd(1, 7, d, l0, l1);
    chk("fill_a5", d, {8{8'hA5}});
    reset = 1'b1;
    step();
    finish_reset(n);
    chk("busy_after_pulse", DW'(n), DW'(DEPTH));
    for (int a = 0; a < DEPTH; a++) begin
      cs = 2'b11; rd = 2'b11; wr = 2'b00;
      addr[0] = AW'(a); addr[1] = AW'(DEPTH - 1 - a);
      step();
    end
    idle();
    repeat (3) step();
    do_rd(0, 20, d, l0, l1);
    chk("cleared_word", d, '0);

    do_wr(0, 5, 64'h0123456789ABCDEF, '1);
    do_wr(0, 5, '1, 8'h0F);
    do_rd(0, 5, d, l0, l1);
    chk("be_word", d, 64'h01234567FFFFFFFF);
    chk("lat_or0", DW'(l0), DW'(1));
    chk("lat_or1", DW'(l1), DW'(2));

    do_wr(0, 9, {8{8'hCC}}, '1);
    cs = 2'b11; wr = 2'b11; rd = 2'b00; addr[0] = 9; addr[1] = 9;
    wd[0] = {8{8'h11}}; wd[1] = {8{8'h22}}; be[0] = 8'h0F; be[1] = 8'hFF;
    step();
    idle();
    do_rd(1, 9, d, l0, l1);
    chk("coll_ww", d, 64'h2222222211111111);
    cs = 2'b11; wr = 2'b01; rd = 2'b10; addr[0] = 9; addr[1] = 9;
    wd[0] = {8{8'h33}}; be[0] = '1;
    step();
    idle();
    wait_rsp(1, d, l0, l1);
    chk("coll_rbw", d, 64'h2222222211111111);
    do_rd(0, 9, d, l0, l1);
    chk("coll_after", d, {8{8'h33}});

    cs[0] = 1'b1; wr[0] = 1'b1; addr[0] = 14; wd[0] = 64'hDEADBEEF00C0FFEE; be[0] = '1;
    step();
    wr[0] = 1'b0; rd[0] = 1'b1;
    step();
    idle();
    wait_rsp(0, d, l0, l1);
    chk("wr_then_rd", d, 64'hDEADBEEF00C0FFEE);

    v0 = vcnt;
    wcnt = 0;
    for (int i = 0; i < 35; i++) begin
      clken = (i >= 10 && i < 13) ? 2'b00 : 2'b11;
      cs = 2'b11; rd = 2'b11; wr = 2'b00;
      addr[0] = AW'(i % DEPTH); addr[1] = AW'((i * 5) % DEPTH);
      #1;
      if (wreq[0][0]) wcnt++;
      step();
    end
    clken = '1;
    idle();
    repeat (4) step();
    chk("stream_wait", DW'(wcnt), DW'(3));
    for (int dd = 0; dd < 2; dd++)
      for (int p = 0; p < 2; p++)
        chk($sformatf("stream_cnt_r%0d_p%0d", dd, p+1), DW'(vcnt[dd][p] - v0[dd][p]), DW'(32));

    do_wr(0, 2, {8{8'h02}}, '1);
    do_wr(0, 50, {8{8'hEE}}, '1);
    do_rd(0, 50, d, l0, l1);
    chk("oor_data", d, '0);
    chk("oor_valid", DW'(l0), DW'(1));
    do_rd(0, 2, d, l0, l1);
    chk("oor_alias", d, {8{8'h02}});

    repeat (600) begin
      for (int p = 0; p < 2; p++) begin
        clken[p] = ($urandom_range(0, 9) != 0);
        cs[p] = ($urandom_range(0, 7) != 0);
        rd[p] = 1'($urandom_range(0, 1));
        wr[p] = ($urandom_range(0, 2) == 0);
        addr[p] = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, 63))
                                              : AW'($urandom_range(8, 10));
        be[p] = BEW'($urandom);
        wd[p] = {$urandom, $urandom};
      end
      step();
    end
    clken = '1;
    idle();
    repeat (4) step();

    cs[0] = 1'b1; rd[0] = 1'b1; addr[0] = 3;
    step();
    addr[0] = 4;
    step();
    idle();
    reset = 1'b1;
    step();
    v0 = vcnt;
    finish_reset(n);
    chk("busy_mid_stream", DW'(n), DW'(DEPTH));
    for (int dd = 0; dd < 2; dd++)
      for (int p = 0; p < 2; p++)
        chk($sformatf("no_valid_after_reset_r%0d_p%0d", dd, p+1),
            DW'(vcnt[dd][p] - v0[dd][p]), DW'(0));

    do_wr(0, 47, {8{8'h5A}}, '1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (20) step();
    reset = 1'b1;
    step();
    finish_reset(n);
    chk("busy_restart", DW'(n), DW'(DEPTH));
    do_rd(1, 47, d, l0, l1);
    chk("restart_last", d, '0);
    do_rd(0, 0, d, l0, l1);
    chk("restart_first", d, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
